bram_fifo_ctrl: RTL
===================

// Module: bram_fifo_ctrl
// PURPOSE
//  FIFO controller that owns both ports of one bram instance (256x16 default) and
//  turns it into a valid/ready stream buffer. Upstream producers push words in;
//  downstream consumers pop them in order. The controller generates the bram write
//  enable, write address, write data and read address, and consumes the bram read data.
//  Both bram clocks are tied to i_clk.
// PARAMETERS
//  ADDR_W  8    bram address width; depth = 2**ADDR_W words
//  DATA_W  16   word width; must match the bram data width
// PORTS
//  i_clk          in   1         single clock; also drives bram i_wclk and i_rclk
//  i_rst          in   1         asynchronous reset, active-high
//  i_wr_valid     in   1         upstream word available
//  o_wr_ready     out  1         controller accepts a word this cycle
//  i_wr_data      in   DATA_W    upstream word
//  o_rd_valid     out  1         o_rd_data holds the FIFO head
//  i_rd_ready     in   1         downstream takes the head this cycle
//  o_rd_data      out  DATA_W    FIFO head; wired from i_bram_rdata
//  o_bram_wr_en   out  1         to bram i_wr_en
//  o_bram_waddr   out  ADDR_W    to bram i_waddr
//  o_bram_wdata   out  DATA_W    to bram i_wdata
//  o_bram_raddr   out  ADDR_W    to bram i_raddr
//  i_bram_rdata   in   DATA_W    from bram o_rdata (registered read, 1-cycle latency)
//  o_count        out  ADDR_W+1  total occupancy (words in bram plus head), 0..2**ADDR_W
// BEHAVIOUR
//  Registers
//  - wptr, rptr: ADDR_W bits; wrap modulo 2**ADDR_W.
//  - mem_cnt: ADDR_W+1 bits; written but not yet fetched.
//  - rd_valid: drives o_rd_valid.
//  Reset (async, immediate)
//  - wptr=rptr=0, mem_cnt=0, o_rd_valid=0, o_count=0.
//  - bram contents are not cleared. Reset mid-operation discards all data.
//  Occupancy
//  - o_count = mem_cnt + rd_valid. The head's bram slot stays occupied until popped.
//  Write side
//  - o_wr_ready = (o_count < 2**ADDR_W), from registered state only.
//  - push = i_wr_valid & o_wr_ready.
//  - o_bram_wr_en = push; o_bram_waddr = wptr; o_bram_wdata = i_wr_data.
//  - On push: wptr <= wptr+1.
//  - At full, o_wr_ready=0 even if a pop occurs that cycle; the push is taken next cycle.
//  Read side
//  - pop = o_rd_valid & i_rd_ready.
//  - fetch = (mem_cnt != 0) & (~o_rd_valid | i_rd_ready).
//  - o_bram_raddr = fetch ? rptr : rptr-1. Holding the head address keeps i_bram_rdata stable.
//  - On fetch: rptr <= rptr+1.
//  - rd_valid <= fetch | (rd_valid & ~i_rd_ready).
//  - o_rd_data = i_bram_rdata, meaningful only while o_rd_valid=1.
//  - o_rd_valid and o_rd_data hold unchanged while i_rd_ready=0.
//  Counts and simultaneous events
//  - mem_cnt <= mem_cnt + push - fetch.
//  - Push and fetch in the same cycle: mem_cnt unchanged.
//  - Push and pop in the same cycle: o_count unchanged.
//  - A push into an empty FIFO (mem_cnt=0) cannot fetch the same cycle.
//  Latency and throughput
//  - Push in cycle t -> fetch in t+1 -> o_rd_valid=1 with data in t+2.
//  - With i_rd_ready held high and mem_cnt>0: one word per cycle, no bubbles.
//  Boundaries
//  - Pointer wrap 255->0 is seamless.
//  - No overflow or underflow is possible: push is gated by o_wr_ready, fetch by mem_cnt.
//  - i_wr_data is ignored when there is no push; i_rd_ready is ignored when o_rd_valid=0.
// TESTING
//  1. Reset; push 0x0005, 0x0012, 0x001F back-to-back with i_rd_ready=0
//     -> o_count=3; o_rd_valid rises 2 cycles after the first push; o_rd_data=0x0005 held.
//  2. Push 256 words (data = index), no pops
//     -> o_wr_ready=0 when o_count=256; extra i_wr_valid gives o_bram_wr_en=0, no wptr change.
//  3. From full, hold i_rd_ready=1
//     -> 256 consecutive pops in order 0..255, one per cycle.
//     -> o_rd_valid falls the cycle after the last pop; o_count reaches 0.
//  4. Continuous push/pop of 300 words (data = index*13+5)
//     -> output order exact across the 255->0 wrap; o_count steady at the same value.
//  5. Random i_wr_valid/i_rd_ready (50%) for 2000 cycles against a scoreboard queue
//     -> no loss, duplication or reordering; o_rd_data stable while stalled.
//  6. Assert i_rst between clock edges mid-stream
//     -> o_rd_valid=0, o_count=0, o_wr_ready=1 without waiting for a clock edge.
//     -> After release, a new push reaches the head after 2 cycles.

Source files
------------

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: valid/ready FIFO controller that owns both ports of one
// simple dual-port bram (registered read, 1-cycle latency) clocked by i_clk.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_wr_valid/o_wr_ready        upstream handshake, i_wr_data payload
//   o_rd_valid/i_rd_ready        downstream handshake, o_rd_data is the head
//   o_bram_wr_en/waddr/wdata     bram write port
//   o_bram_raddr/i_bram_rdata    bram read port
//   o_count                      occupancy (words in bram plus head), 0..2**ADDR_W
module bram_fifo_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_bram_wr_en,
  output logic [ADDR_W-1:0] o_bram_waddr,
  output logic [DATA_W-1:0] o_bram_wdata,
  output logic [ADDR_W-1:0] o_bram_raddr,
  input  logic [DATA_W-1:0] i_bram_rdata,
  output logic [ADDR_W:0]   o_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
  logic              rd_valid_q, rd_valid_d;

  logic [CNT_W-1:0]  count_c;
  logic              push_c;
  logic              fetch_c;

  // Occupancy and handshakes, derived from registered state only.
  always_comb begin
    count_c = mem_cnt_q + CNT_W'(rd_valid_q);
    push_c  = i_wr_valid & (count_c < CNT_W'(DEPTH));
    fetch_c = (mem_cnt_q != '0) & (~rd_valid_q | i_rd_ready);
  end

  // Next state. Holding raddr on the head slot keeps i_bram_rdata stable
  // while the consumer stalls.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_cnt_d  = mem_cnt_q + CNT_W'(push_c) - CNT_W'(fetch_c);
    rd_valid_d = fetch_c | (rd_valid_q & ~i_rd_ready);
    if (push_c)  wptr_d = wptr_q + ADDR_W'(1);
    if (fetch_c) rptr_d = rptr_q + ADDR_W'(1);
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_cnt_q  <= mem_cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_wr_ready   = count_c < CNT_W'(DEPTH);
  assign o_count      = count_c;
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_data    = i_bram_rdata;
  assign o_bram_wr_en = push_c;
  assign o_bram_waddr = wptr_q;
  assign o_bram_wdata = i_wr_data;
  assign o_bram_raddr = fetch_c ? rptr_q : rptr_q - ADDR_W'(1);

endmodule
